// File: rtl/wb_queue.sv
// Write-back queue: merges load results and ALU results into a circular FIFO
// that drains one entry per cycle into the register-file write port. It also
// provides a pending-write lookup so decode can forward queued values.
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [4:0]  mem_addr,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        alu_valid,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    output logic        RegWrite,
    output logic [4:0]  WriteAddr,
    output logic [31:0] WriteData,
    input  logic [4:0]  chk_addr1,
    input  logic [4:0]  chk_addr2,
    output logic        hit1,
    output logic        hit2,
    output logic [31:0] fwd_data1,
    output logic [31:0] fwd_data2,
    output logic [4:0]  count,
    output logic        full,
    output logic        empty,
    output logic        overflow_err
);

    localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] L_DEPTH = 5'(DEPTH);

    // Entry storage; contents only matter while covered by r_count, so no reset.
    logic [4:0]    r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [4:0]    r_count;
    logic          r_ovf;

    logic          w_mem_acc;
    logic          w_alu_acc;
    logic          w_mem_enq;
    logic          w_alu_enq;
    logic          w_pop;
    logic          w_ovf_set;
    logic [4:0]    w_n_enq;
    logic [PW-1:0] w_alu_slot;
    logic [PW-1:0] w_idx;

    // Readiness uses only the registered count: no credit for the same-cycle pop.
    assign mem_ready  = (r_count <= (L_DEPTH - 5'd1));
    assign alu_ready  = (r_count <= (L_DEPTH - 5'd2));

    // Writes to $zero complete the handshake but are never queued.
    assign w_mem_acc  = mem_valid & mem_ready;
    assign w_alu_acc  = alu_valid & alu_ready;
    assign w_mem_enq  = w_mem_acc & (mem_addr != 5'd0);
    assign w_alu_enq  = w_alu_acc & (alu_addr != 5'd0);
    assign w_pop      = (r_count != 5'd0);
    assign w_ovf_set  = (mem_valid & ~mem_ready) | (alu_valid & ~alu_ready);
    assign w_n_enq    = 5'(w_mem_enq) + 5'(w_alu_enq);
    // The ALU entry lands behind the mem entry when both enqueue together.
    assign w_alu_slot = r_tail + PW'(w_mem_enq);

    // The register file always accepts, so the head is presented whenever non-empty.
    assign RegWrite   = w_pop;
    assign WriteAddr  = w_pop ? r_addr[r_head] : 5'd0;
    assign WriteData  = w_pop ? r_data[r_head] : 32'd0;

    assign count        = r_count;
    assign full         = (r_count == L_DEPTH);
    assign empty        = (r_count == 5'd0);
    assign overflow_err = r_ovf;

    // Control state: pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 5'd0;
            r_ovf   <= 1'b0;
        end else begin
            r_head  <= r_head + PW'(w_pop);
            r_tail  <= r_tail + PW'(w_n_enq);
            r_count <= r_count + w_n_enq - 5'(w_pop);
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Entry storage writes: mem first (older), alu second.
    always_ff @(posedge clock) begin
        if (w_mem_enq) begin
            r_addr[r_tail] <= mem_addr;
            r_data[r_tail] <= mem_data;
        end
        if (w_alu_enq) begin
            r_addr[w_alu_slot] <= alu_addr;
            r_data[w_alu_slot] <= alu_data;
        end
    end

    // Pending-write lookup, scanned oldest to youngest so the youngest match wins.
    always_comb begin
        hit1      = 1'b0;
        hit2      = 1'b0;
        fwd_data1 = 32'd0;
        fwd_data2 = 32'd0;
        w_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if ((5'(i) < r_count) && (chk_addr1 != 5'd0) && (r_addr[w_idx] == chk_addr1)) begin
                hit1      = 1'b1;
                fwd_data1 = r_data[w_idx];
            end
            if ((5'(i) < r_count) && (chk_addr2 != 5'd0) && (r_addr[w_idx] == chk_addr2)) begin
                hit2      = 1'b1;
                fwd_data2 = r_data[w_idx];
            end
        end
    end

endmodule
